text_overlay_engine: RTL and testbench

Parametrised block-font text renderer for the VGA path of the maze game. It replaces the fixed per-message overlays with one programmable engine. It holds a string of up to MAX_CHARS character codes loaded through a valid/ready port, and renders them in the game's 5x5 block font at a configurable block size and screen origin. It reveals the string one character at a time ("typewriter"), and can optionally blink. The one-bit pixel output goes to the colour mux alongside the maze and player layers.

---
 rtl/text_pkg.sv | 30 +++
 rtl/text_overlay_engine_if.sv | 37 +++
 rtl/text_glyph_rom.sv | 76 +++++++
 rtl/text_overlay_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_text_overlay_engine.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// ----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text overlay engine:
//   - char_code_t : 6-bit character code (0-9 digits, 10-35 A-Z, 36 '!',
//                   37 ':', anything else renders blank)
//   - CH_* constants for the code map
//   - glyph geometry (5x5 glyph, 7-block pitch)
//   - glyph_bit_index(): bit position of (gy,gx) inside a 25-bit bitmap
// ----------------------------------------------------------------------------
package text_pkg;

    typedef logic [5:0] char_code_t;

    localparam char_code_t CH_0     = 6'd0;
    localparam char_code_t CH_A     = 6'd10;
    localparam char_code_t CH_EXCL  = 6'd36;
    localparam char_code_t CH_COLON = 6'd37;
    localparam char_code_t CH_BLANK = 6'd63;

    localparam int GLYPH_W     = 5;
    localparam int GLYPH_H     = 5;
    localparam int GLYPH_PITCH = 7;

    // Bitmaps store the top row in bits [24:20], leftmost pixel as the MSB
    // of each row, so pixel (gy,gx) lives at bit 24 - (gy*5 + gx).
    function automatic logic [4:0] glyph_bit_index(input logic [2:0] gy, input logic [2:0] gx);
        return 5'd24 - (({2'b00, gy} * 5'd5) + {2'b00, gx});
    endfunction

endpackage

// File: rtl/text_overlay_engine_if.sv
// ----------------------------------------------------------------------------
// text_overlay_engine_if
// Character-load handshake into the overlay string buffer.
//   load_valid : write request            (master -> slave)
//   load_index : buffer slot               (master -> slave)
//   load_char  : character code            (master -> slave)
//   load_last  : write also sets length    (master -> slave)
//   load_ready : write accepted this cycle (slave  -> master)
// IDX_W must equal $clog2(MAX_CHARS) of the engine it connects to.
// ----------------------------------------------------------------------------
interface text_overlay_engine_if
    import text_pkg::*;
#(
    parameter int IDX_W = 3
);
    logic             load_valid;
    logic             load_ready;
    logic [IDX_W-1:0] load_index;
    char_code_t       load_char;
    logic             load_last;

    modport master (
        output load_valid,
        output load_index,
        output load_char,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_index,
        input  load_char,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/text_glyph_rom.sv
// ----------------------------------------------------------------------------
// text_glyph_rom
// Combinational 5x5 block-font lookup.
//   code  : character code
//   gy,gx : block row / column inside the glyph (0..4; larger gives 0)
//   pixel : 1 when that block of the glyph is lit
// ----------------------------------------------------------------------------
module text_glyph_rom
    import text_pkg::*;
(
    input  char_code_t code,
    input  logic [2:0] gy,
    input  logic [2:0] gx,
    output logic       pixel
);

    logic [24:0] bitmap_s;
    logic [4:0]  bit_idx_s;

    // Font bitmaps, one row of five blocks per underscore group, top row first
    always_comb begin
        bitmap_s = 25'd0;
        case (code)
            6'd0:  bitmap_s = 25'b01110_10011_10101_11001_01110;
            6'd1:  bitmap_s = 25'b00100_01100_00100_00100_01110;
            6'd2:  bitmap_s = 25'b11110_00001_01110_10000_11111;
            6'd3:  bitmap_s = 25'b11110_00001_00110_00001_11110;
            6'd4:  bitmap_s = 25'b10010_10010_11111_00010_00010;
            6'd5:  bitmap_s = 25'b11111_10000_11110_00001_11110;
            6'd6:  bitmap_s = 25'b01110_10000_11110_10001_01110;
            6'd7:  bitmap_s = 25'b11111_00010_00100_01000_01000;
            6'd8:  bitmap_s = 25'b01110_10001_01110_10001_01110;
            6'd9:  bitmap_s = 25'b01110_10001_01111_00001_01110;
            6'd10: bitmap_s = 25'b01110_10001_11111_10001_10001; // A
            6'd11: bitmap_s = 25'b11110_10001_11110_10001_11110; // B
            6'd12: bitmap_s = 25'b01111_10000_10000_10000_01111; // C
            6'd13: bitmap_s = 25'b11110_10001_10001_10001_11110; // D
            6'd14: bitmap_s = 25'b11111_10000_11110_10000_11111; // E
            6'd15: bitmap_s = 25'b11111_10000_11110_10000_10000; // F
            6'd16: bitmap_s = 25'b01111_10000_10011_10001_01111; // G
            6'd17: bitmap_s = 25'b10001_10001_11111_10001_10001; // H
            6'd18: bitmap_s = 25'b11111_00100_00100_00100_11111; // I
            6'd19: bitmap_s = 25'b00111_00010_00010_10010_01100; // J
            6'd20: bitmap_s = 25'b10010_10100_11000_10100_10010; // K
            6'd21: bitmap_s = 25'b10000_10000_10000_10000_11111; // L
            6'd22: bitmap_s = 25'b10001_11011_10101_10001_10001; // M
            6'd23: bitmap_s = 25'b10001_11001_10101_10011_10001; // N
            6'd24: bitmap_s = 25'b01110_10001_10001_10001_01110; // O
            6'd25: bitmap_s = 25'b11110_10001_11110_10000_10000; // P
            6'd26: bitmap_s = 25'b01110_10001_10101_10010_01101; // Q
            6'd27: bitmap_s = 25'b11110_10001_11110_10100_10010; // R
            6'd28: bitmap_s = 25'b01111_10000_01110_00001_11110; // S
            6'd29: bitmap_s = 25'b11111_00100_00100_00100_00100; // T
            6'd30: bitmap_s = 25'b10001_10001_10001_10001_01110; // U
            6'd31: bitmap_s = 25'b10001_10001_10001_01010_00100; // V
            6'd32: bitmap_s = 25'b10001_10001_10101_11011_10001; // W
            6'd33: bitmap_s = 25'b10001_01010_00100_01010_10001; // X
            6'd34: bitmap_s = 25'b10001_01010_00100_00100_00100; // Y
            6'd35: bitmap_s = 25'b11111_00010_00100_01000_11111; // Z
            6'd36: bitmap_s = 25'b00100_00100_00100_00000_00100; // !
            6'd37: bitmap_s = 25'b00000_00100_00000_00100_00000; // :
            default: bitmap_s = 25'd0;
        endcase
    end

    // Pick the addressed block; positions outside the 5x5 cell are dark
    always_comb begin
        bit_idx_s = glyph_bit_index(gy, gx);
        if ((gx < 3'd5) && (gy < 3'd5)) begin
            pixel = bitmap_s[bit_idx_s];
        end else begin
            pixel = 1'b0;
        end
    end

endmodule

// File: rtl/text_overlay_engine.sv
// ----------------------------------------------------------------------------
// text_overlay_engine
// Programmable block-font text overlay with typewriter reveal.
// Parameters: SCALE (pixels per font block), MAX_CHARS (buffer depth, >= 2),
//             REVEAL_FRAMES (frame_ticks per revealed char, 0 = instant),
//             BLINK_FRAMES (frame_ticks per blink half-period).
// Ports:
//   clk, rst             pixel clock, synchronous active-high reset
//   xCount, yCount       current pixel position
//   frame_tick, vblank   frame pulse / vertical blanking flag
//   origin_x, origin_y   top-left corner of the text box
//   load_if (slave)      character-write handshake, ready only in vblank
//   start                restart reveal from zero characters
//   enable               gates text_pixel
//   text_pixel           pixel is text (2-cycle latency from coordinates)
//   reveal_done          whole non-empty string is revealed
// Optional feature: define TEXT_BLINK_EN to blink the text with a
// BLINK_FRAMES half-period; without it the text is steady.
// ----------------------------------------------------------------------------
module text_overlay_engine
    import text_pkg::*;
#(
    parameter int SCALE         = 10,
    parameter int MAX_CHARS     = 8,
    parameter int REVEAL_FRAMES = 4,
    parameter int BLINK_FRAMES  = 30
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           xCount,
    input  logic [9:0]           yCount,
    input  logic                 frame_tick,
    input  logic                 vblank,
    input  logic [9:0]           origin_x,
    input  logic [9:0]           origin_y,
    text_overlay_engine_if.slave load_if,
    input  logic                 start,
    input  logic                 enable,
    output logic                 text_pixel,
    output logic                 reveal_done
);

    localparam int IDX_W     = $clog2(MAX_CHARS);
    localparam int LEN_W     = $clog2(MAX_CHARS + 1);
    localparam int BUF_DEPTH = 1 << IDX_W;
    localparam int PRE_W     = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'((REVEAL_FRAMES > 0) ? REVEAL_FRAMES - 1 : 0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    // ---------------- load handshake and string buffer ----------------
    logic             wr_s;
    logic             idx_ok_s;
    logic [IDX_W-1:0] ld_idx_s;

    // Buffer is rounded up to a power of two so any index read is in range;
    // slots at or beyond MAX_CHARS are never written and stay blank.
    char_code_t       buf_r [BUF_DEPTH];
    logic [LEN_W-1:0] len_r;

    assign load_if.load_ready = vblank & ~rst;
    assign ld_idx_s = load_if.load_index;
    assign wr_s     = load_if.load_valid & vblank & ~rst;
    assign idx_ok_s = ({1'b0, ld_idx_s} < (IDX_W + 1)'(MAX_CHARS));

    // String buffer and length; out-of-range writes handshake but are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_r[i] <= CH_BLANK;
            end
            len_r <= '0;
        end else if (wr_s && idx_ok_s) begin
            buf_r[ld_idx_s] <= load_if.load_char;
            if (load_if.load_last) begin
                len_r <= LEN_W'(ld_idx_s) + LEN_ONE;
            end
        end
    end

    // ---------------- reveal counter ----------------
    logic [LEN_W-1:0] rc_r;
    logic [PRE_W-1:0] pre_r;

    // Typewriter count: start wins over frame_tick; saturates at length
    always_ff @(posedge clk) begin
        if (rst || start) begin
            rc_r  <= '0;
            pre_r <= '0;
        end else if (REVEAL_FRAMES == 0) begin
            rc_r  <= len_r;
            pre_r <= '0;
        end else if (frame_tick) begin
            if (pre_r == PRE_LAST) begin
                pre_r <= '0;
                if (rc_r < len_r) begin
                    rc_r <= rc_r + LEN_ONE;
                end
            end else begin
                pre_r <= pre_r + PRE_ONE;
            end
        end
    end

    // ---------------- optional blink ----------------
    logic blink_ok_s;

`ifdef TEXT_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

    logic [BLK_W-1:0] blink_cnt_r;
    logic             blink_hidden_r;

    // Blink phase toggles every BLINK_FRAMES frames; start returns it to visible
    always_ff @(posedge clk) begin
        if (rst || start) begin
            blink_cnt_r    <= '0;
            blink_hidden_r <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_r == BLK_LAST) begin
                blink_cnt_r    <= '0;
                blink_hidden_r <= ~blink_hidden_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLK_ONE;
            end
        end
    end

    assign blink_ok_s = ~blink_hidden_r;
`else
    assign blink_ok_s = 1'b1;
`endif

    // ---------------- pixel stage 1: box geometry ----------------
    logic [9:0]       rx_s, ry_s, col_s, row_s, char_s, gx_full_s;
    logic             in_box_s;
    logic             in_box_r;
    logic [IDX_W-1:0] char_r;
    logic [2:0]       gx_r, gy_r;

    // Box-relative block coordinates; the >= tests stop the subtraction wrapping
    always_comb begin
        rx_s      = xCount - origin_x;
        ry_s      = yCount - origin_y;
        col_s     = rx_s / 10'(SCALE);
        row_s     = ry_s / 10'(SCALE);
        char_s    = col_s / 10'(GLYPH_PITCH);
        gx_full_s = col_s % 10'(GLYPH_PITCH);
        if ((xCount >= origin_x) && (yCount >= origin_y) &&
            (row_s < 10'(GLYPH_H)) && (gx_full_s < 10'(GLYPH_W)) &&
            (char_s < 10'(MAX_CHARS))) begin
            in_box_s = 1'b1;
        end else begin
            in_box_s = 1'b0;
        end
    end

    // Stage-1 register of in-box flag, character slot and glyph position
    always_ff @(posedge clk) begin
        if (rst) begin
            in_box_r <= 1'b0;
            char_r   <= '0;
            gx_r     <= 3'd0;
            gy_r     <= 3'd0;
        end else begin
            in_box_r <= in_box_s;
            char_r   <= char_s[IDX_W-1:0];
            gx_r     <= gx_full_s[2:0];
            gy_r     <= row_s[2:0];
        end
    end

    // ---------------- pixel stage 2: glyph and gates ----------------
    logic [LEN_W-1:0] shown_s;
    char_code_t       cur_char_s;
    logic             glyph_bit_s;
    logic             pix_s;
    logic             text_pixel_r;
    logic             reveal_done_r;

    text_glyph_rom u_rom (
        .code  (cur_char_s),
        .gy    (gy_r),
        .gx    (gx_r),
        .pixel (glyph_bit_s)
    );

    // Character is shown when its slot is below min(rc, length)
    always_comb begin
        cur_char_s = buf_r[char_r];
        if (rc_r < len_r) begin
            shown_s = rc_r;
        end else begin
            shown_s = len_r;
        end
        if (in_box_r && glyph_bit_s && enable && blink_ok_s &&
            (LEN_W'(char_r) < shown_s)) begin
            pix_s = 1'b1;
        end else begin
            pix_s = 1'b0;
        end
    end

    // Registered pixel and completion flag
    always_ff @(posedge clk) begin
        if (rst) begin
            text_pixel_r  <= 1'b0;
            reveal_done_r <= 1'b0;
        end else begin
            text_pixel_r  <= pix_s;
            reveal_done_r <= (rc_r >= len_r) && (len_r != '0);
        end
    end

    assign text_pixel  = text_pixel_r;
    assign reveal_done = reveal_done_r;

endmodule

// File: tb/tb_text_overlay_engine.sv
// ----------------------------------------------------------------------------
// tb_text_overlay_engine
// Two engines on shared video timing:
//   u_big   : SCALE=10, MAX_CHARS=8, REVEAL_FRAMES=0, origin (200,200)
//   u_small : SCALE=2,  MAX_CHARS=6, REVEAL_FRAMES=2, origin (600,10)
// Both hold "WIN!" (W=32, I=18, N=23, !=36). BLINK_FRAMES=3 on both.
// ----------------------------------------------------------------------------
module tb_text_overlay_engine;
    import text_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] xCount, yCount;
    logic       frame_tick, vblank, start, enable;
    logic [9:0] ox_big, oy_big, ox_small, oy_small;
    logic       pix_big, done_big, pix_small, done_small;

    int n_checks = 0;
    int n_fail   = 0;

    text_overlay_engine_if #(.IDX_W(3)) if_big ();
    text_overlay_engine_if #(.IDX_W(3)) if_small ();

    text_overlay_engine #(.SCALE(10), .MAX_CHARS(8), .REVEAL_FRAMES(0), .BLINK_FRAMES(3)) u_big (
        .clk(clk), .rst(rst), .xCount(xCount), .yCount(yCount),
        .frame_tick(frame_tick), .vblank(vblank),
        .origin_x(ox_big), .origin_y(oy_big),
        .load_if(if_big.slave), .start(start), .enable(enable),
        .text_pixel(pix_big), .reveal_done(done_big)
    );

    text_overlay_engine #(.SCALE(2), .MAX_CHARS(6), .REVEAL_FRAMES(2), .BLINK_FRAMES(3)) u_small (
        .clk(clk), .rst(rst), .xCount(xCount), .yCount(yCount),
        .frame_tick(frame_tick), .vblank(vblank),
        .origin_x(ox_small), .origin_y(oy_small),
        .load_if(if_small.slave), .start(start), .enable(enable),
        .text_pixel(pix_small), .reveal_done(done_small)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_xy(input int x, input int y);
        xCount = 10'(x);
        yCount = 10'(y);
        tick();
        tick();
    endtask

    task automatic load_pair(input int idx, input int ch, input logic last);
        if_big.load_valid   = 1'b1;
        if_big.load_index   = 3'(idx);
        if_big.load_char    = 6'(ch);
        if_big.load_last    = last;
        if_small.load_valid = 1'b1;
        if_small.load_index = 3'(idx);
        if_small.load_char  = 6'(ch);
        if_small.load_last  = last;
        tick();
        if_big.load_valid   = 1'b0;
        if_small.load_valid = 1'b0;
        if_big.load_last    = 1'b0;
        if_small.load_last  = 1'b0;
    endtask

    initial begin
        logic exp_pix;
        rst = 1'b1; vblank = 1'b1; frame_tick = 1'b0; start = 1'b0; enable = 1'b1;
        xCount = 10'd0; yCount = 10'd0;
        ox_big = 10'd200; oy_big = 10'd200; ox_small = 10'd600; oy_small = 10'd10;
        if_big.load_valid = 1'b0; if_big.load_index = 3'd0; if_big.load_char = 6'd0; if_big.load_last = 1'b0;
        if_small.load_valid = 1'b0; if_small.load_index = 3'd0; if_small.load_char = 6'd0; if_small.load_last = 1'b0;

        // Reset state
        #1;
        check_val("ready_in_rst", if_big.load_ready, 1'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check_val("ready_vblank", if_big.load_ready, 1'b1);
        check_val("rst_pix", pix_big, 1'b0);
        check_val("rst_done", done_big, 1'b0);
        check_val("rst_rc", u_small.rc_r, 0);

        // Load "WIN!" into both engines
        load_pair(0, 32, 1'b0);
        load_pair(1, 18, 1'b0);
        load_pair(2, 23, 1'b0);
        load_pair(3, 36, 1'b1);
        tick(); tick(); tick();
        check_val("big_done_instant", done_big, 1'b1);
        check_val("small_done_pre", done_small, 1'b0);
        vblank = 1'b0;

        // Two-cycle latency and glyph pixels, SCALE=10
        xCount = 10'd200; yCount = 10'd200;
        tick();
        check_val("lat_1cyc", pix_big, 1'b0);
        tick();
        check_val("lat_2cyc_W_tl", pix_big, 1'b1);
        at_xy(250, 200); check_val("gap_250", pix_big, 1'b0);
        at_xy(220, 200); check_val("W_r0_gx2", pix_big, 1'b0);
        at_xy(210, 230); check_val("W_r3_gx1", pix_big, 1'b1);
        at_xy(270, 200); check_val("I_r0_gx0", pix_big, 1'b1);
        at_xy(430, 200); check_val("excl_top", pix_big, 1'b1);
        at_xy(480, 200); check_val("char4_blank", pix_big, 1'b0);
        at_xy(200, 250); check_val("below_box", pix_big, 1'b0);

        // Write outside vblank is refused
        if_big.load_valid = 1'b1; if_big.load_index = 3'd0; if_big.load_char = 6'd10;
        #1;
        check_val("ready_no_vblank", if_big.load_ready, 1'b0);
        tick();
        if_big.load_valid = 1'b0;
        at_xy(200, 200); check_val("buf_unchanged", pix_big, 1'b1);

        // Out-of-range index on the 6-slot engine
        vblank = 1'b1;
        if_small.load_valid = 1'b1; if_small.load_index = 3'd6; if_small.load_char = 6'd0; if_small.load_last = 1'b1;
        #1;
        check_val("oor_ready", if_small.load_ready, 1'b1);
        tick();
        if_small.load_valid = 1'b0; if_small.load_last = 1'b0;
        vblank = 1'b0;
        tick();
        check_val("oor_len", u_small.len_r, 4);

        // Typewriter reveal on the small engine, watching character 3
        start = 1'b1; tick(); start = 1'b0;
        check_val("rv_start_rc", u_small.rc_r, 0);
        at_xy(646, 10);
        check_val("rv_c3_hidden0", pix_small, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0;
            check_val($sformatf("rv_rc_k%0d", k), u_small.rc_r, k / 2);
            check_val($sformatf("rv_done_lag_k%0d", k), done_small, 1'b0);
            tick();
            check_val($sformatf("rv_c3_pix_k%0d", k), pix_small, (k == 8) ? 1'b1 : 1'b0);
            check_val($sformatf("rv_done_k%0d", k), done_small, (k == 8) ? 1'b1 : 1'b0);
        end

        // Enable gate
        enable = 1'b0; tick();
        check_val("enable_off", pix_small, 1'b0);
        enable = 1'b1; tick();
        check_val("enable_on", pix_small, 1'b1);

        // SCALE=2 geometry
        at_xy(599, 10);  check_val("s2_left_of_box", pix_small, 1'b0);
        at_xy(600, 10);  check_val("s2_blk00", pix_small, 1'b1);
        at_xy(601, 11);  check_val("s2_blk11", pix_small, 1'b1);
        at_xy(602, 10);  check_val("s2_next_blk", pix_small, 1'b0);
        at_xy(600, 9);   check_val("s2_above_box", pix_small, 1'b0);
        at_xy(614, 10);  check_val("s2_I_tl", pix_small, 1'b1);
        at_xy(1023, 10); check_val("s2_x1023", pix_small, 1'b0);

        // Blink sweep on the big engine (steady when blink is not built in)
        start = 1'b1; tick(); start = 1'b0;
        at_xy(200, 200);
        for (int f = 0; f <= 8; f++) begin
            exp_pix = 1'b1;
`ifdef TEXT_BLINK_EN
            if ((f >= 3) && (f <= 5)) exp_pix = 1'b0;
`endif
            check_val($sformatf("blink_f%0d", f), pix_big, exp_pix);
            frame_tick = 1'b1; tick(); frame_tick = 1'b0;
            tick(); tick();
        end

        // start beats a same-cycle frame_tick
        start = 1'b1; frame_tick = 1'b1; tick(); start = 1'b0; frame_tick = 1'b0;
        check_val("start_vs_tick_rc", u_small.rc_r, 0);
        for (int k = 0; k < 2; k++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
        end
        check_val("rc_after_2_ticks", u_small.rc_r, 1);
        at_xy(600, 10);
        check_val("c0_shown_rc1", pix_small, 1'b1);
        check_val("big_done_pre_rst", done_big, 1'b1);

        // Reset mid-reveal
        rst = 1'b1; tick();
        check_val("midrst_pix", pix_small, 1'b0);
        check_val("midrst_rc", u_small.rc_r, 0);
        check_val("midrst_done_big", done_big, 1'b0);
        check_val("midrst_done_small", done_small, 1'b0);
        rst = 1'b0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
